hwag_event_sched: RTL and testbench

- Angle-event scheduler behind the HWAG angle counter.
- Drives CH output channels (ignition/injection style) from the free-running crank angle (acnt2 domain, 0..ANGLE_TOP).
- A single shared wrap-aware window comparator is time-multiplexed round-robin across channels, one channel per clock.
- Per-channel on/off angles are programmed via a shadow/active register pair with glitch-free commit.

---
 rtl/hwag_sched_pkg.sv | 15 +
 rtl/hwag_event_sched_if.sv | 25 ++
 rtl/hwag_angle_window.sv | 14 +
 rtl/hwag_event_sched.sv | 84 ++++++++
 tb/tb_hwag_event_sched.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/hwag_sched_pkg.sv
// hwag_sched_pkg: shared constants and types for the angle-event scheduler
// Provides CH/AW/ANGLE_TOP, the channel index width, angle_t, window_t and the on/off select codes.
package hwag_sched_pkg;
   localparam int CH = 8;
   localparam int AW = 24;
   localparam int ANGLE_TOP = 3839;
   localparam int CW = $clog2(CH);
   typedef logic [AW-1:0] angle_t;
   typedef struct packed {
      angle_t on;
      angle_t off;
   } window_t;
   localparam logic CFG_ON = 1'b0;
   localparam logic CFG_OFF = 1'b1;
endpackage

// File: rtl/hwag_event_sched_if.sv
// hwag_event_sched_if: angle/config/mask bus into the scheduler and channel/event outputs back
// master drives ena, acnt, cfg_*, ch_mask; slave (the scheduler) drives ch_out, ev_*, cfg_err.
interface hwag_event_sched_if;
   import hwag_sched_pkg::*;
   logic ena;
   angle_t acnt;
   logic cfg_we;
   logic [CW-1:0] cfg_ch;
   logic cfg_sel;
   angle_t cfg_data;
   logic [CH-1:0] ch_mask;
   logic [CH-1:0] ch_out;
   logic ev_if;
   logic [CW-1:0] ev_ch;
   logic ev_lvl;
   logic cfg_err;
   modport master (
      output ena, acnt, cfg_we, cfg_ch, cfg_sel, cfg_data, ch_mask,
      input ch_out, ev_if, ev_ch, ev_lvl, cfg_err
   );
   modport slave (
      input ena, acnt, cfg_we, cfg_ch, cfg_sel, cfg_data, ch_mask,
      output ch_out, ev_if, ev_ch, ev_lvl, cfg_err
   );
endinterface

// File: rtl/hwag_angle_window.sv
// hwag_angle_window: combinational wrap-aware angle window test
// Ports: i_angle (angle under test), i_win (on/off pair), o_in (angle lies inside the window).
module hwag_angle_window
   import hwag_sched_pkg::*;
(
   input  angle_t  i_angle,
   input  window_t i_win,
   output logic    o_in
);
   // on==off means the channel is disabled; on>off is a window spanning the angle wrap
   always_comb
      o_in = (i_win.on < i_win.off) ? (i_angle >= i_win.on) && (i_angle < i_win.off) :
             (i_win.on > i_win.off) ? (i_angle >= i_win.on) || (i_angle < i_win.off) : 1'b0;
endmodule

// File: rtl/hwag_event_sched.sv
// hwag_event_sched: round-robin angle-window scheduler driving CH channel outputs
// Ports: i_clk; i_rst_n (async, active-low); bus (slave): ena/acnt/cfg_*/ch_mask in,
// ch_out/ev_if/ev_ch/ev_lvl/cfg_err out.
module hwag_event_sched
   import hwag_sched_pkg::*;
(
   input logic i_clk,
   input logic i_rst_n,
   hwag_event_sched_if.slave bus
);
   logic [CW-1:0] r_ptr, r_idx_q, r_ev_ch;
   angle_t r_acnt_q;
   window_t r_shadow [CH];
   window_t r_active [CH];
   logic [CH-1:0] r_pend, r_ch_out;
   logic r_res_q, r_valid, r_ev_if, r_ev_lvl, r_cfg_err;
   logic w_in, w_wr_bad, w_wr_ok;

   assign w_wr_bad = bus.cfg_we & (bus.cfg_data > angle_t'(ANGLE_TOP));
   assign w_wr_ok = bus.cfg_we & ~w_wr_bad;

   hwag_angle_window u_win (
      .i_angle (r_acnt_q),
      .i_win   (r_active[r_ptr]),
      .o_in    (w_in)
   );

   always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n) begin
         r_ptr <= '0;
         r_acnt_q <= '0;
         r_pend <= '0;
         r_res_q <= 1'b0;
         r_idx_q <= '0;
         r_valid <= 1'b0;
         r_ch_out <= '0;
         r_ev_if <= 1'b0;
         r_ev_ch <= '0;
         r_ev_lvl <= 1'b0;
         r_cfg_err <= 1'b0;
         for (int k = 0; k < CH; k++) begin
            r_shadow[k] <= '0;
            r_active[k] <= '0;
         end
      end else begin
         r_ptr <= bus.ena ? r_ptr + CW'(1) : '0;
         // one coherent angle sample per sweep; tracks acnt while idle so a restart sees a fresh value
         if (!bus.ena || r_ptr == CW'(CH - 1))
            r_acnt_q <= bus.acnt;
         r_valid <= bus.ena;
         r_res_q <= w_in & bus.ch_mask[r_ptr] & bus.ena;
         r_idx_q <= r_ptr;
         // the forced clear on ena drop produces no event
         r_ev_if <= bus.ena & r_valid & (r_ch_out[r_idx_q] != r_res_q);
         r_ev_ch <= r_idx_q;
         r_ev_lvl <= r_res_q;
         if (!bus.ena)
            r_ch_out <= '0;
         else if (r_valid)
            r_ch_out[r_idx_q] <= r_res_q;
         r_cfg_err <= w_wr_bad;
         for (int k = 0; k < CH; k++) begin
            // commit only while the channel is off so a live pulse keeps its window
            if (r_pend[k] && (!bus.ena || (r_ptr == CW'(k) && !r_ch_out[k]))) begin
               r_active[k] <= r_shadow[k];
               r_pend[k] <= 1'b0;
            end
            // a same-cycle write wins over the commit clear, so the new value commits later
            if (w_wr_ok && bus.cfg_ch == CW'(k)) begin
               r_pend[k] <= 1'b1;
               if (bus.cfg_sel == CFG_OFF)
                  r_shadow[k].off <= bus.cfg_data;
               else
                  r_shadow[k].on <= bus.cfg_data;
            end
         end
      end

   assign bus.ch_out = r_ch_out;
   assign bus.ev_if = r_ev_if;
   assign bus.ev_ch = r_ev_ch;
   assign bus.ev_lvl = r_ev_lvl;
   assign bus.cfg_err = r_cfg_err;
endmodule

// File: tb/tb_hwag_event_sched.sv
// tb_hwag_event_sched: directed self-checking bench for hwag_event_sched
module tb_hwag_event_sched;
   import hwag_sched_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n;
   logic [CW-1:0] q_ch[$];
   logic q_lvl[$];
   int q_cyc[$];

   hwag_event_sched_if bus();

   hwag_event_sched dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (bus.ev_if === 1'b1) begin
         q_ch.push_back(bus.ev_ch);
         q_lvl.push_back(bus.ev_lvl);
         q_cyc.push_back(cyc);
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int c);
      repeat (c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic cfg(input int ch, input logic sel, input int data, input logic exp_err);
      bus.cfg_we = 1'b1;
      bus.cfg_ch = CW'(ch);
      bus.cfg_sel = sel;
      bus.cfg_data = angle_t'(data);
      tick(1);
      bus.cfg_we = 1'b0;
      chk($sformatf("cfg_err ch%0d=%0d", ch, data), 32'(bus.cfg_err), 32'(exp_err));
   endtask

   task automatic step(input int a, input logic [CH-1:0] exp);
      bus.acnt = angle_t'(a);
      tick(3 * CH);
      chk($sformatf("ch_out@%0d", a), 32'(bus.ch_out), 32'(exp));
   endtask

   function automatic int cnt(input int from, input int ch);
      int r = 0;
      for (int i = from; i < q_ch.size(); i++)
         if (int'(q_ch[i]) == ch) r++;
      return r;
   endfunction

   initial begin
      bus.ena = 1'b0;
      bus.acnt = '0;
      bus.cfg_we = 1'b0;
      bus.cfg_ch = '0;
      bus.cfg_sel = 1'b0;
      bus.cfg_data = '0;
      bus.ch_mask = '0;
      tick(3);
      chk("rst ch_out", 32'(bus.ch_out), 0);
      chk("rst ev_if", 32'(bus.ev_if), 0);
      chk("rst ev_ch", 32'(bus.ev_ch), 0);
      chk("rst ev_lvl", 32'(bus.ev_lvl), 0);
      chk("rst cfg_err", 32'(bus.cfg_err), 0);
      rst_n = 1'b1;
      tick(1);
      cfg(0, CFG_ON, 100, 1'b0);
      cfg(0, CFG_OFF, 200, 1'b0);
      cfg(1, CFG_ON, 300, 1'b0);
      cfg(1, CFG_OFF, 400, 1'b0);
      cfg(1, CFG_ON, 3840, 1'b1);
      tick(1);
      chk("cfg_err one cycle", 32'(bus.cfg_err), 0);
      cfg(2, CFG_ON, 500, 1'b0);
      cfg(2, CFG_OFF, 900, 1'b0);
      cfg(3, CFG_ON, 3800, 1'b0);
      cfg(3, CFG_OFF, 40, 1'b0);
      tick(2);
      bus.ch_mask = 8'h0F;
      bus.ena = 1'b1;
      n = q_ch.size();
      step(0, 8'h08);
      step(50, 8'h00);
      step(100, 8'h01);
      chk("rise ev_ch", 32'(q_ch[$]), 0);
      chk("rise ev_lvl", 32'(q_lvl[$]), 1);
      step(199, 8'h01);
      step(200, 8'h00);
      step(350, 8'h02);
      step(550, 8'h04);
      cfg(2, CFG_ON, 600, 1'b0);
      cfg(2, CFG_OFF, 700, 1'b0);
      step(650, 8'h04);
      step(800, 8'h04);
      step(900, 8'h00);
      step(3839, 8'h08);
      step(0, 8'h08);
      step(39, 8'h08);
      step(40, 8'h00);
      step(550, 8'h00);
      step(650, 8'h04);
      step(700, 8'h00);
      chk("events ch0", cnt(n, 0), 2);
      chk("events ch1", cnt(n, 1), 2);
      chk("events ch2", cnt(n, 2), 4);
      chk("events ch3", cnt(n, 3), 4);

      cfg(5, CFG_ON, 100, 1'b0);
      cfg(5, CFG_OFF, 200, 1'b0);
      bus.ch_mask = 8'h21;
      step(150, 8'h21);
      n = q_ch.size();
      bus.ena = 1'b0;
      tick(1);
      chk("ena drop ch_out", 32'(bus.ch_out), 0);
      chk("ena drop ev_if", 32'(bus.ev_if), 0);
      tick(4);
      chk("ena drop no events", q_ch.size(), n);

      bus.ena = 1'b1;
      step(150, 8'h21);
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      chk("async rst ch_out", 32'(bus.ch_out), 0);
      chk("async rst ev_if", 32'(bus.ev_if), 0);
      bus.ena = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(1);
      cfg(0, CFG_ON, 100, 1'b0);
      cfg(0, CFG_OFF, 200, 1'b0);
      bus.ch_mask = 8'h01;
      bus.acnt = angle_t'(150);
      tick(2);
      bus.ena = 1'b1;
      tick(1);
      chk("restart c1 ch_out", 32'(bus.ch_out), 0);
      chk("restart c1 ev_if", 32'(bus.ev_if), 0);
      tick(1);
      chk("restart c2 ch_out", 32'(bus.ch_out), 1);
      chk("restart c2 ev_if", 32'(bus.ev_if), 1);
      chk("restart c2 ev_ch", 32'(bus.ev_ch), 0);
      chk("restart c2 ev_lvl", 32'(bus.ev_lvl), 1);
      tick(1);
      chk("restart c3 ev_if", 32'(bus.ev_if), 0);

      n = q_ch.size();
      bus.ch_mask = 8'h00;
      tick(3 * CH);
      chk("mask clr ch_out", 32'(bus.ch_out), 0);
      chk("mask clr events", q_ch.size(), n + 1);
      chk("mask clr ev_ch", 32'(q_ch[$]), 0);
      chk("mask clr ev_lvl", 32'(q_lvl[$]), 0);

      bus.ena = 1'b0;
      tick(1);
      for (int i = 0; i < CH; i++) begin
         cfg(i, CFG_ON, 1000, 1'b0);
         cfg(i, CFG_OFF, 1010, 1'b0);
      end
      bus.ch_mask = 8'hFF;
      bus.acnt = angle_t'(500);
      tick(2);
      bus.ena = 1'b1;
      tick(3 * CH);
      chk("all8 idle ch_out", 32'(bus.ch_out), 0);
      n = q_ch.size();
      step(1000, 8'hFF);
      chk("all8 events", q_ch.size(), n + 8);
      if (q_ch.size() >= n + 8)
         for (int i = 0; i < 8; i++) begin
            chk($sformatf("all8 ev_ch %0d", i), 32'(q_ch[n + i]), i);
            chk($sformatf("all8 ev_lvl %0d", i), 32'(q_lvl[n + i]), 1);
            chk($sformatf("all8 cyc %0d", i), q_cyc[n + i] - q_cyc[n], i);
         end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
